// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multicycle MIPS datapath. Sequences each
// instruction through fetch, decode, execute, memory and writeback, one cycle
// per step, and drives the datapath enables, mux selects and the 2-bit aluOp
// consumed by ALU control. Memory accesses stall on memReady.
//
// Build option:
//   MC_CONTROL_BNE_EN  - when defined, opcode 000101 (bne) is dispatched to
//                        BRANCH with branchNe asserted. When undefined, bne
//                        is an illegal opcode and branchNe is tied low.
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       branchNe,
  output logic       iOrD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output logic [3:0] stateOut
);

  // ---------------------------------------------------------------------------
  // State encoding. Codes 12..15 are unused; the FSM recovers from them to
  // FETCH with all outputs low.
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  // Opcodes recognised in DECODE (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  // aluOp encodings understood by ALU control.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // aluSrcB selects.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BTGT = 2'b11;

  // pcSource selects.
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // Every control output gathered in one record so the output decoder can
  // clear them all with a single default assignment.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  state_t dispatch;
  logic   opcode_legal;
  ctrl_t  ctrl;

  // Decode the opcode once: where DECODE goes next and whether it is legal.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case leaves it unassigned (no latch).
    dispatch     = FETCH;
    opcode_legal = 1'b1;
    case (opcode)
      OP_RTYPE:      dispatch = EXEC;
      OP_LW, OP_SW:  dispatch = MEMADR;
      OP_BEQ:        dispatch = BRANCH;
`ifdef MC_CONTROL_BNE_EN
      OP_BNE:        dispatch = BRANCH;
`endif
      OP_ADDI:       dispatch = ADDIEX;
      OP_J:          dispatch = JUMP;
      default:       opcode_legal = 1'b0;
    endcase
  end

  // State register: reset forces FETCH immediately, abandoning any
  // instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic: single-cycle steps, with the three memory states
  // holding until memReady.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = memReady ? DECODE : FETCH;
      DECODE:  state_d = dispatch;
      MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = memReady ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = memReady ? FETCH : MEMWR;
      EXEC:    state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode: Moore outputs from state, except that memReady gates the
  // PC/IR writes in FETCH and opcode qualifies illegalOp and branchNe.
  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = memReady;
        ctrl.pc_write  = memReady;
      end
      DECODE: begin
        ctrl.alu_src_b  = SRCB_BTGT;
        ctrl.illegal_op = ~opcode_legal;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_OUT;
        ctrl.pc_write_cond = 1'b1;
`ifdef MC_CONTROL_BNE_EN
        ctrl.branch_ne     = (opcode == OP_BNE);
`endif
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: begin
        ctrl.pc_source = PCSRC_ALU;
      end
    endcase
  end

  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign branchNe    = ctrl.branch_ne;
  assign iOrD        = ctrl.i_or_d;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign irWrite     = ctrl.ir_write;
  assign regDst      = ctrl.reg_dst;
  assign memToReg    = ctrl.mem_to_reg;
  assign regWrite    = ctrl.reg_write;
  assign aluSrcA     = ctrl.alu_src_a;
  assign aluSrcB     = ctrl.alu_src_b;
  assign aluOp       = ctrl.alu_op;
  assign pcSource    = ctrl.pc_source;
  assign illegalOp   = ctrl.illegal_op;
  assign stateOut    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed, table-driven bench for multicycle_control. Each row gives the
// inputs for one clock cycle and the state/control outputs expected during
// that cycle. Hand-written sequences follow for asynchronous reset in the
// middle of an instruction. Honours MC_CONTROL_BNE_EN for the bne rows.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, branchNe;
  logic       iOrD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic       illegalOp;
  logic [3:0] stateOut;

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .memReady    (memReady),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .branchNe    (branchNe),
    .iOrD        (iOrD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .irWrite     (irWrite),
    .regDst      (regDst),
    .memToReg    (memToReg),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .pcSource    (pcSource),
    .illegalOp   (illegalOp),
    .stateOut    (stateOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word layout (bench-local):
  // {pcWrite, pcWriteCond, branchNe, iOrD, memRead, memWrite, irWrite,
  //  regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp}
  typedef logic [17:0] cw_t;

  function automatic cw_t mk(input logic pcw, input logic pcwc, input logic bne,
                             input logic iord, input logic mr, input logic mw,
                             input logic irw, input logic rd, input logic m2r,
                             input logic rw, input logic asa, input logic [1:0] asb,
                             input logic [1:0] aop, input logic [1:0] psrc,
                             input logic ill);
    return {pcw, pcwc, bne, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ill};
  endfunction

  // Expected control words, written out from the state/output table.
  //                                pcw pcwc bne iod mr mw irw rd m2r rw asa asb    aop    psrc   ill
  localparam cw_t C_FETCH_S   = mk(0,  0,   0,  0,  1, 0, 0,  0, 0,  0, 0,  2'b01, 2'b00, 2'b00, 0);
  localparam cw_t C_FETCH_G   = mk(1,  0,   0,  0,  1, 0, 1,  0, 0,  0, 0,  2'b01, 2'b00, 2'b00, 0);
  localparam cw_t C_DECODE    = mk(0,  0,   0,  0,  0, 0, 0,  0, 0,  0, 0,  2'b11, 2'b00, 2'b00, 0);
  localparam cw_t C_DECODE_IL = mk(0,  0,   0,  0,  0, 0, 0,  0, 0,  0, 0,  2'b11, 2'b00, 2'b00, 1);
  localparam cw_t C_MEMADR    = mk(0,  0,   0,  0,  0, 0, 0,  0, 0,  0, 1,  2'b10, 2'b00, 2'b00, 0);
  localparam cw_t C_MEMRD     = mk(0,  0,   0,  1,  1, 0, 0,  0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 0);
  localparam cw_t C_MEMWB     = mk(0,  0,   0,  0,  0, 0, 0,  0, 1,  1, 0,  2'b00, 2'b00, 2'b00, 0);
  localparam cw_t C_MEMWR     = mk(0,  0,   0,  1,  0, 1, 0,  0, 0,  0, 0,  2'b00, 2'b00, 2'b00, 0);
  localparam cw_t C_EXEC      = mk(0,  0,   0,  0,  0, 0, 0,  0, 0,  0, 1,  2'b00, 2'b10, 2'b00, 0);
  localparam cw_t C_ALUWB     = mk(0,  0,   0,  0,  0, 0, 0,  1, 0,  1, 0,  2'b00, 2'b00, 2'b00, 0);
  localparam cw_t C_BRANCH    = mk(0,  1,   0,  0,  0, 0, 0,  0, 0,  0, 1,  2'b00, 2'b01, 2'b01, 0);
  localparam cw_t C_ADDIEX    = mk(0,  0,   0,  0,  0, 0, 0,  0, 0,  0, 1,  2'b10, 2'b00, 2'b00, 0);
  localparam cw_t C_ADDIWB    = mk(0,  0,   0,  0,  0, 0, 0,  0, 0,  1, 0,  2'b00, 2'b00, 2'b00, 0);
  localparam cw_t C_JUMP      = mk(1,  0,   0,  0,  0, 0, 0,  0, 0,  0, 0,  2'b00, 2'b00, 2'b10, 0);
`ifdef MC_CONTROL_BNE_EN
  localparam cw_t C_BRANCH_NE = mk(0,  1,   1,  0,  0, 0, 0,  0, 0,  0, 1,  2'b00, 2'b01, 2'b01, 0);
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    cw_t        cw;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic cw_t dut_cw();
    return {pcWrite, pcWriteCond, branchNe, iOrD, memRead, memWrite, irWrite,
            regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};
  endfunction

  task automatic check(input string name, input logic [3:0] exp_st, input cw_t exp_cw);
    cw_t got;
    got = dut_cw();
    n_vec++;
    if (stateOut !== exp_st || got !== exp_cw) begin
      n_bad++;
      $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
               name, stateOut, got, exp_st, exp_cw);
    end
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input cw_t cw, input string name);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.st = st; v.cw = cw; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after the falling edge, then sample mid-cycle.
  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input cw_t cw, input string name);
    @(negedge clk);
    rst_n    = rst;
    opcode   = op;
    memReady = mr;
    #1;
    check(name, st, cw);
  endtask

  initial begin
    rst_n    = 1'b1;
    opcode   = OP_R;
    memReady = 1'b0;
    #1 rst_n = 1'b0;

    //   rst op       mr  state  control       name
    add(0, OP_R,    0, 4'd0,  C_FETCH_S,   "reset_idle");
    add(0, OP_R,    1, 4'd0,  C_FETCH_G,   "reset_memready");
    add(1, OP_R,    1, 4'd0,  C_FETCH_G,   "first_fetch_ready");
    add(1, OP_R,    1, 4'd1,  C_DECODE,    "r_decode");
    add(1, OP_R,    0, 4'd6,  C_EXEC,      "r_exec");
    add(1, OP_R,    1, 4'd7,  C_ALUWB,     "r_aluwb");
    add(1, OP_R,    1, 4'd0,  C_FETCH_G,   "lw_fetch");
    add(1, OP_LW,   0, 4'd1,  C_DECODE,    "lw_decode");
    add(1, OP_LW,   1, 4'd2,  C_MEMADR,    "lw_memadr");
    add(1, OP_LW,   0, 4'd3,  C_MEMRD,     "lw_memrd_stall1");
    add(1, OP_LW,   0, 4'd3,  C_MEMRD,     "lw_memrd_stall2");
    add(1, OP_LW,   1, 4'd3,  C_MEMRD,     "lw_memrd_done");
    add(1, OP_LW,   0, 4'd4,  C_MEMWB,     "lw_memwb");
    add(1, OP_LW,   0, 4'd0,  C_FETCH_S,   "sw_fetch_stall");
    add(1, OP_LW,   1, 4'd0,  C_FETCH_G,   "sw_fetch");
    add(1, OP_SW,   1, 4'd1,  C_DECODE,    "sw_decode");
    add(1, OP_SW,   1, 4'd2,  C_MEMADR,    "sw_memadr");
    add(1, OP_SW,   0, 4'd5,  C_MEMWR,     "sw_memwr_stall");
    add(1, OP_SW,   1, 4'd5,  C_MEMWR,     "sw_memwr_done");
    add(1, OP_SW,   1, 4'd0,  C_FETCH_G,   "beq_fetch");
    add(1, OP_BEQ,  1, 4'd1,  C_DECODE,    "beq_decode");
    add(1, OP_BEQ,  1, 4'd8,  C_BRANCH,    "beq_branch");
    add(1, OP_BEQ,  1, 4'd0,  C_FETCH_G,   "j_fetch");
    add(1, OP_J,    1, 4'd1,  C_DECODE,    "j_decode");
    add(1, OP_J,    1, 4'd11, C_JUMP,      "j_jump");
    add(1, OP_J,    1, 4'd0,  C_FETCH_G,   "addi_fetch");
    add(1, OP_ADDI, 0, 4'd1,  C_DECODE,    "addi_decode");
    add(1, OP_ADDI, 1, 4'd9,  C_ADDIEX,    "addi_ex");
    add(1, OP_ADDI, 0, 4'd10, C_ADDIWB,    "addi_wb");
    add(1, OP_ADDI, 1, 4'd0,  C_FETCH_G,   "ill_fetch");
    add(1, OP_BAD,  1, 4'd1,  C_DECODE_IL, "ill_decode");
    add(1, OP_BAD,  1, 4'd0,  C_FETCH_G,   "ill_refetch");
`ifdef MC_CONTROL_BNE_EN
    add(1, OP_BNE,  1, 4'd1,  C_DECODE,    "bne_decode");
    add(1, OP_BNE,  1, 4'd8,  C_BRANCH_NE, "bne_branch");
    add(1, OP_BNE,  1, 4'd0,  C_FETCH_G,   "bne_refetch");
`else
    add(1, OP_BNE,  1, 4'd1,  C_DECODE_IL, "bne_decode_illegal");
    add(1, OP_BNE,  1, 4'd0,  C_FETCH_G,   "bne_no_branch");
`endif

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].cw, vecs[i].name);

    // Asynchronous reset in the middle of EXEC.
    step(0, OP_R, 1, 4'd0, C_FETCH_G, "seq1_reset");
    step(1, OP_R, 1, 4'd0, C_FETCH_G, "seq1_fetch");
    step(1, OP_R, 1, 4'd1, C_DECODE,  "seq1_decode");
    step(1, OP_R, 1, 4'd6, C_EXEC,    "seq1_exec");
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_exec", 4'd0, C_FETCH_G);
    step(1, OP_R, 0, 4'd0, C_FETCH_S, "seq1_restart");

    // Asynchronous reset while a store is stalled: the write must drop.
    step(1, OP_R,  1, 4'd0, C_FETCH_G, "seq2_fetch");
    step(1, OP_SW, 1, 4'd1, C_DECODE,  "seq2_decode");
    step(1, OP_SW, 1, 4'd2, C_MEMADR,  "seq2_memadr");
    step(1, OP_SW, 0, 4'd5, C_MEMWR,   "seq2_memwr");
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_memwr", 4'd0, C_FETCH_S);
    step(1, OP_SW, 0, 4'd0, C_FETCH_S, "seq2_restart");
    step(1, OP_SW, 0, 4'd0, C_FETCH_S, "seq2_fetch_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
